spram_fifo_ctrl: RTL

Synchronous FIFO controller that sits directly upstream of the single-port RAM `spram` (WD/AD parameterised, `cs_n`/`w_r_n`/`addr`/`din`/`dout`). It turns push/pop handshakes into RAM chip-select, write/read, address and data cycles, and returns read data from `spram.dout`. Read and write share the one RAM port, so the block arbitrates between a push and a pop requested in the same cycle. Pointer, count and flag logic live here; storage lives in `spram`.

---
 rtl/spram_fifo_ctrl_if.sv | 39 +++
 rtl/spram_fifo_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/spram_fifo_ctrl_if.sv
// Bundles the FIFO handshake, status flags and the single-port RAM bus of spram_fifo_ctrl.
// The master side is the producer/consumer plus the RAM; the slave side is the controller.
interface spram_fifo_ctrl_if #(
   parameter int unsigned WD = 8,
   parameter int unsigned AD = 4
);
   logic          push;
   logic [WD-1:0] push_data;
   logic          push_ready;
   logic          pop;
   logic          pop_ready;
   logic [WD-1:0] pop_data;
   logic          pop_valid;
   logic [AD:0]   count;
   logic          empty;
   logic          full;
   logic          almost_full;
   logic          ovf_err;
   logic          unf_err;
   logic          mem_cs_n;
   logic          mem_w_r_n;
   logic [AD-1:0] mem_addr;
   logic [WD-1:0] mem_din;
   logic [WD-1:0] mem_dout;

   modport master (
      output push, push_data, pop, mem_dout,
      input  push_ready, pop_ready, pop_data, pop_valid, count,
             empty, full, almost_full, ovf_err, unf_err,
             mem_cs_n, mem_w_r_n, mem_addr, mem_din
   );

   modport slave (
      input  push, push_data, pop, mem_dout,
      output push_ready, pop_ready, pop_data, pop_valid, count,
             empty, full, almost_full, ovf_err, unf_err,
             mem_cs_n, mem_w_r_n, mem_addr, mem_din
   );
endinterface

// File: rtl/spram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM: turns push/pop handshakes into RAM cycles,
// tracks pointers/occupancy, and arbitrates the shared port with pops taking priority.
module spram_fifo_ctrl #(
   parameter int unsigned WD     = 8,
   parameter int unsigned AD     = 4,
   parameter int unsigned AF_LVL = 12
) (
   input logic            clk,
   input logic            rst,
   spram_fifo_ctrl_if.slave bus
);
   localparam int unsigned CW    = AD + 1;
   localparam int unsigned DEPTH = 1 << AD;

   logic [AD-1:0] wr_ptr;
   logic [AD-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          pop_valid_q;
   logic          ovf_q;
   logic          unf_q;

   logic          empty_c;
   logic          full_c;
   logic          pop_ok_c;
   logic          push_ok_c;
   logic          pop_fire;
   logic          push_fire;

   assign empty_c = (cnt == '0);
   assign full_c  = (cnt == CW'(DEPTH));

   // A legal pop owns the RAM port this cycle; an illegal pop (empty) does not block a push.
   always_comb begin
      pop_ok_c  = 1'b0;
      push_ok_c = 1'b0;
      if (!rst) begin
         pop_ok_c  = !empty_c;
         push_ok_c = !full_c && !(bus.pop && !empty_c);
      end
   end

   assign pop_fire  = bus.pop  && pop_ok_c;
   assign push_fire = bus.push && push_ok_c;

   // RAM port drive; idle cycles park address and data at zero.
   always_comb begin
      bus.mem_cs_n  = 1'b1;
      bus.mem_w_r_n = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_din   = '0;
      if (pop_fire) begin
         bus.mem_cs_n  = 1'b0;
         bus.mem_addr  = rd_ptr;
      end else if (push_fire) begin
         bus.mem_cs_n  = 1'b0;
         bus.mem_w_r_n = 1'b1;
         bus.mem_addr  = wr_ptr;
         bus.mem_din   = bus.push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cnt         <= '0;
         pop_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         if (push_fire) wr_ptr <= wr_ptr + AD'(1);
         if (pop_fire)  rd_ptr <= rd_ptr + AD'(1);
         case ({push_fire, pop_fire})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
         pop_valid_q <= pop_fire;
         if (bus.push && full_c)  ovf_q <= 1'b1;
         if (bus.pop  && empty_c) unf_q <= 1'b1;
      end
   end

   // Arbitration guarantees the port is never claimed twice in one cycle.
   always_comb begin
      assert (!(push_fire && pop_fire));
   end

   assign bus.push_ready  = push_ok_c;
   assign bus.pop_ready   = pop_ok_c;
   assign bus.pop_valid   = pop_valid_q;
   assign bus.pop_data    = pop_valid_q ? bus.mem_dout : '0;
   assign bus.count       = cnt;
   assign bus.empty       = empty_c;
   assign bus.full        = full_c;
   assign bus.almost_full = (cnt >= CW'(AF_LVL));
   assign bus.ovf_err     = ovf_q;
   assign bus.unf_err     = unf_q;
endmodule
